// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared sweep direction type and mode encodings
package led_scan_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;

endpackage

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED channel -- duty register with optional afterglow decay and PWM comparator
module led_pwm_chan #(
    parameter int PWM_W   = 10,
    parameter int TAIL_SH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [PWM_W-1:0] i_ctr,
    input  logic [PWM_W-1:0] i_target,
    output logic [PWM_W-1:0] o_duty,
    output logic             o_led
);

    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_shifted;
    logic [PWM_W-1:0] w_step;
    logic [PWM_W-1:0] w_decayed;
    logic [PWM_W-1:0] w_duty_nxt;

    // Decay step is at least 1 so a small duty still fades fully to zero
    assign w_shifted  = r_duty >> TAIL_SH;
    assign w_step     = (w_shifted == '0) ? PWM_W'(1) : w_shifted;
    assign w_decayed  = (r_duty > w_step) ? r_duty - w_step : '0;
    assign w_duty_nxt = (TAIL_SH == 0 || i_target > w_decayed) ? i_target : w_decayed;
    assign o_duty     = r_duty;

    // Duty only changes at the PWM period boundary; output is the registered compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
            o_led  <= 1'b0;
        end else begin
            if (i_load)
                r_duty <= w_duty_nxt;
            o_led <= (i_ctr < r_duty);
        end
    end

endmodule

// File: rtl/led_scanner.sv
// led_scanner: bounce/wrap sweep of a bright spot across N_LEDS PWM channels
module led_scanner
    import led_scan_pkg::*;
#(
    parameter int N_LEDS  = 8,
    parameter int PWM_W   = 10,
    parameter int FRAC_W  = 21,
    parameter int TAIL_SH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] led
);

    localparam int IDX_W = $clog2(N_LEDS);
    localparam int POS_W = IDX_W + FRAC_W;
    localparam logic [POS_W:0] POS_MAX = (POS_W+1)'(N_LEDS - 1) << FRAC_W;
    localparam logic [POS_W:0] POS_LEN = (POS_W+1)'(N_LEDS) << FRAC_W;
    localparam logic [PWM_W-1:0] PEAK = '1;

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    dir_t             r_dir;
    dir_t             w_dir_nxt;
    logic [PWM_W-1:0] r_pwm_ctr;
    logic [POS_W:0]   w_inc;
    logic [POS_W:0]   w_sum;
    logic [POS_W:0]   w_pos_ext;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_nidx;
    logic             w_nx_en;
    logic [PWM_W-1:0] w_f;
    logic             w_boundary;
    logic [PWM_W-1:0] w_target [N_LEDS];
    logic [PWM_W-1:0] w_duty   [N_LEDS];

    // Sums are one bit wider than pos so the clamp/wrap compares never overflow
    assign w_inc      = (POS_W+1)'({1'b0, speed} + 3'd1);
    assign w_pos_ext  = {1'b0, r_pos};
    assign w_sum      = w_pos_ext + w_inc;
    assign w_idx      = r_pos[POS_W-1 -: IDX_W];
    assign w_f        = r_pos[FRAC_W-1 -: PWM_W];
    assign w_nidx     = (w_idx == IDX_W'(N_LEDS - 1)) ? '0 : w_idx + IDX_W'(1);
    assign w_nx_en    = (w_idx != IDX_W'(N_LEDS - 1)) || (mode == MODE_WRAP);
    assign w_boundary = (r_pwm_ctr == PEAK);

    // Sweep position and direction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
            r_dir <= UP;
        end else begin
            r_pos <= w_pos_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    // Next sweep position: wrap modulo the ring, or bounce clamped at both ends
    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (en) begin
            if (mode == MODE_WRAP) begin
                w_dir_nxt = UP;
                w_pos_nxt = (w_sum >= POS_LEN) ? POS_W'(w_sum - POS_LEN) : POS_W'(w_sum);
            end else if (r_dir == UP) begin
                w_pos_nxt = (w_sum >= POS_MAX) ? POS_W'(POS_MAX) : POS_W'(w_sum);
                w_dir_nxt = (w_sum >= POS_MAX) ? DOWN : UP;
            end else begin
                w_pos_nxt = (w_pos_ext <= w_inc) ? '0 : POS_W'(w_pos_ext - w_inc);
                w_dir_nxt = (w_pos_ext <= w_inc) ? UP : DOWN;
            end
        end
    end

    // Crossfade between the current LED and its successor by the fractional position
    always_comb begin
        for (int i = 0; i < N_LEDS; i++)
            w_target[i] = (w_idx == IDX_W'(i)) ? PEAK - w_f :
                          (w_nx_en && w_nidx == IDX_W'(i)) ? w_f : '0;
    end

    // Free-running PWM counter, wraps naturally from PEAK to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pwm_ctr <= '0;
        else
            r_pwm_ctr <= r_pwm_ctr + PWM_W'(1);
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_W   (PWM_W),
            .TAIL_SH (TAIL_SH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_boundary),
            .i_ctr    (r_pwm_ctr),
            .i_target (w_target[i]),
            .o_duty   (w_duty[i]),
            .o_led    (led[i])
        );
    end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed stimulus with a behavioural sweep/PWM model and per-cycle compare
module tb_led_scanner;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [3:0] led0;
    logic [3:0] led1;

    int n_vec  = 0;
    int n_fail = 0;
    int hi [4];

    int         m_pos = 0;
    int         m_dir = 0;
    int         m_ctr = 0;
    int         m_d0 [4] = '{0, 0, 0, 0};
    int         m_d1 [4] = '{0, 0, 0, 0};
    logic [3:0] m_l0 = 4'd0;
    logic [3:0] m_l1 = 4'd0;

    always #5 clk = ~clk;

    led_scanner #(.N_LEDS(4), .PWM_W(4), .FRAC_W(6), .TAIL_SH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .speed(speed), .led(led0)
    );

    led_scanner #(.N_LEDS(4), .PWM_W(4), .FRAC_W(6), .TAIL_SH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .speed(speed), .led(led1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Brightness each channel should aim for, from position 0..255 (64 steps per LED, 4 per PWM level)
    function automatic int tgt(input int p, input logic md, input int ch);
        int idx = p / 64;
        int f   = (p % 64) / 4;
        if (ch == idx) return 15 - f;
        if (ch == (idx + 1) % 4 && (idx != 3 || md)) return f;
        return 0;
    endfunction

    function automatic int fade(input int d, input int t, input int sh);
        int s;
        int r;
        if (sh == 0) return t;
        s = ((d >> sh) > 0) ? (d >> sh) : 1;
        r = (d > s) ? d - s : 0;
        return (t > r) ? t : r;
    endfunction

    // Reference model of sweep, duty and LED output
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0;
            m_dir <= 0;
            m_ctr <= 0;
            m_l0  <= 4'd0;
            m_l1  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                m_d0[i] <= 0;
                m_d1[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_l0[i] <= (m_ctr < m_d0[i]);
                m_l1[i] <= (m_ctr < m_d1[i]);
                if (m_ctr == 15) begin
                    m_d0[i] <= fade(m_d0[i], tgt(m_pos, mode, i), 0);
                    m_d1[i] <= fade(m_d1[i], tgt(m_pos, mode, i), 1);
                end
            end
            m_ctr <= (m_ctr + 1) % 16;
            if (en) begin
                if (mode) begin
                    m_pos <= (m_pos + int'(speed) + 1) % 256;
                    m_dir <= 0;
                end else if (m_dir == 0) begin
                    m_pos <= (m_pos + int'(speed) + 1 >= 192) ? 192 : m_pos + int'(speed) + 1;
                    m_dir <= (m_pos + int'(speed) + 1 >= 192) ? 1 : 0;
                end else begin
                    m_pos <= (m_pos <= int'(speed) + 1) ? 0 : m_pos - int'(speed) - 1;
                    m_dir <= (m_pos <= int'(speed) + 1) ? 0 : 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        chk("pos0", int'(dut0.r_pos), m_pos);
        chk("dir0", int'(dut0.r_dir), m_dir);
        chk("pos1", int'(dut1.r_pos), m_pos);
        chk("ctr0", int'(dut0.r_pwm_ctr), m_ctr);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("duty0[%0d]", i), int'(dut0.w_duty[i]), m_d0[i]);
            chk($sformatf("duty1[%0d]", i), int'(dut1.w_duty[i]), m_d1[i]);
            chk($sformatf("led0[%0d]", i), int'(led0[i]), int'(m_l0[i]));
            chk($sformatf("led1[%0d]", i), int'(led1[i]), int'(m_l1[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic count_led(input int n);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) hi[i] += int'(led0[i]);
        end
    endtask

    task automatic wait_boundary();
        int k = 0;
        while (m_ctr != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("boundary_wait", (k < 40) ? 1 : 0, 1);
    endtask

    initial begin
        int exp_decay [4] = '{4, 2, 1, 0};
        step(3);
        chk("rst_pos", int'(dut0.r_pos), 0);
        chk("rst_led0", int'(led0), 0);
        chk("rst_led1", int'(led1), 0);
        rst_n = 1'b1;

        // Parked at pos 0: only LED 0 lit, 15 of 16 cycles
        step(20);
        count_led(16);
        chk("p0_led0_hi", hi[0], 15);
        chk("p0_led1_hi", hi[1], 0);
        chk("p0_led2_hi", hi[2], 0);
        chk("p0_led3_hi", hi[3], 0);

        // Hold at pos 70 with en low, then one fast step
        en = 1'b1;
        step(70);
        en = 1'b0;
        step(34);
        count_led(16);
        chk("hold_pos70", int'(dut0.r_pos), 70);
        chk("hold_led1_hi", hi[1], 14);
        chk("hold_led2_hi", hi[2], 1);
        en    = 1'b1;
        speed = 2'd3;
        step(1);
        chk("hold_pos74", int'(dut0.r_pos), 74);
        en    = 1'b0;
        speed = 2'd0;

        // Asynchronous reset in the middle of a sweep
        do_reset();
        en = 1'b1;
        step(100);
        chk("pre_rst_pos100", int'(dut0.r_pos), 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led0", int'(led0), 0);
        chk("async_led1", int'(led1), 0);
        chk("async_pos", int'(dut0.r_pos), 0);
        chk("async_dir", int'(dut0.r_dir), 0);
        chk("async_duty1", int'(dut0.w_duty[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bounce: climb to the top, turn, descend, fast hit of the bottom
        step(192);
        chk("bnc_pos192", int'(dut0.r_pos), 192);
        chk("bnc_dir_down", int'(dut0.r_dir), 1);
        chk("model_pos192", m_pos, 192);
        step(1);
        chk("bnc_pos191", int'(dut0.r_pos), 191);
        step(189);
        chk("bnc_pos2", int'(dut0.r_pos), 2);
        speed = 2'd3;
        step(1);
        chk("bnc_pos0", int'(dut0.r_pos), 0);
        chk("bnc_dir_up", int'(dut0.r_dir), 0);

        // Afterglow: full LED 2, then move away and watch it fade
        speed = 2'd0;
        step(128);
        chk("tail_pos128", int'(dut1.r_pos), 128);
        en = 1'b0;
        step(17);
        chk("tail_full", int'(dut1.w_duty[2]), 15);
        chk("model_tail_full", m_d1[2], 15);
        wait_boundary();
        en    = 1'b1;
        speed = 2'd3;
        step(16);
        en = 1'b0;
        chk("tail_pos192", int'(dut1.r_pos), 192);
        chk("tail_d8", int'(dut1.w_duty[2]), 8);
        chk("tail_nodecay", int'(dut0.w_duty[2]), 0);
        for (int k = 0; k < 4; k++) begin
            step(16);
            chk($sformatf("tail_d%0d", exp_decay[k]), int'(dut1.w_duty[2]), exp_decay[k]);
        end

        // Wrap mode: crossfade from LED 3 into LED 0, then roll over
        do_reset();
        mode  = 1'b1;
        speed = 2'd0;
        en    = 1'b1;
        step(224);
        chk("wrap_pos224", int'(dut0.r_pos), 224);
        en = 1'b0;
        step(17);
        chk("wrap_duty3", int'(dut0.w_duty[3]), 7);
        chk("wrap_duty0", int'(dut0.w_duty[0]), 8);
        chk("model_wrap_duty0", m_d0[0], 8);
        en = 1'b1;
        step(31);
        chk("wrap_pos255", int'(dut0.r_pos), 255);
        step(1);
        chk("wrap_pos0", int'(dut0.r_pos), 0);
        chk("wrap_dir_up", int'(dut0.r_dir), 0);

        // Mode and speed changes mid-sweep, checked by the model only
        for (int k = 0; k < 12; k++) begin
            mode  = k[0];
            speed = 2'(k % 4);
            en    = (k % 5 != 4);
            step(37);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
